// File: rtl/sram_bank_we.sv
// Synchronous RAM with one read port, one write port, per-word write enables and registered read data.
// Optional macro SRAM_RESET_CLEAR_EN: reset also clears every row of the array.
module sram_bank_we #(
    parameter int WIDTH        = 64,
    parameter int LOG_NUM_ROWS = 4,
    parameter int WORD_SIZE    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LOG_NUM_ROWS-1:0] readAddr,
    input  logic [LOG_NUM_ROWS-1:0] writeAddr,
    input  logic [WIDTH-1:0]        writeData,
    input  logic [WIDTH/WORD_SIZE-1:0] writeEnable,
    output logic [WIDTH-1:0]        readData
);
    localparam int NUM_ROWS  = 1 << LOG_NUM_ROWS;
    localparam int NUM_WORDS = WIDTH / WORD_SIZE;

    if (WIDTH % WORD_SIZE != 0) begin : g_width_check
        $error("sram_bank_we: WIDTH must be a multiple of WORD_SIZE");
    end

`ifdef SRAM_RESET_CLEAR_EN
    logic [WIDTH-1:0] mem_q [NUM_ROWS];
`else
    // Array starts cleared so unwritten rows never read back as X.
    logic [WIDTH-1:0] mem_q [NUM_ROWS] = '{default: '0};
`endif

    logic [WIDTH-1:0] read_d;
    logic [WIDTH-1:0] read_q;

    // Write-first per word: a same-row write overrides only the enabled words.
    always_comb begin
        read_d = mem_q[readAddr];
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (writeEnable[i] && (readAddr == writeAddr)) begin
                read_d[i*WORD_SIZE +: WORD_SIZE] = writeData[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_q <= '0;
`ifdef SRAM_RESET_CLEAR_EN
            for (int r = 0; r < NUM_ROWS; r++) begin
                mem_q[r] <= '0;
            end
`endif
        end else begin
            read_q <= read_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (writeEnable[i]) begin
                    mem_q[writeAddr][i*WORD_SIZE +: WORD_SIZE] <= writeData[i*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    assign readData = read_q;
endmodule

// File: tb/tb_sram_bank_we.sv
// Bench for sram_bank_we: a 512x32 data-array instance and a 54-bit tag instance checked against a word-level model.
// Honours SRAM_RESET_CLEAR_EN when the same macro is defined for the bench.
module tb_sram_bank_we;
    localparam int DW   = 512;
    localparam int WS   = 32;
    localparam int NW   = DW / WS;
    localparam int LR   = 4;
    localparam int NR   = 1 << LR;
    localparam int TAGW = 54;

    logic          clk = 1'b0;
    logic          reset;
    logic [LR-1:0] raddr, waddr;
    logic [DW-1:0] wdata;
    logic [NW-1:0] we;
    logic [DW-1:0] rdata;
    logic [LR-1:0] t_raddr, t_waddr;
    logic [TAGW-1:0] t_wdata;
    logic [0:0]    t_we;
    logic [TAGW-1:0] t_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: rows held as arrays of words, tags as plain values.
    logic [WS-1:0]   m [NR][NW];
    logic [TAGW-1:0] t [NR];
    logic [DW-1:0]   exp_q [$];
    logic [TAGW-1:0] tag_q [$];

    always #5 clk = ~clk;

    sram_bank_we #(.WIDTH(DW), .LOG_NUM_ROWS(LR), .WORD_SIZE(WS)) u_data (
        .clk(clk), .reset(reset), .readAddr(raddr), .writeAddr(waddr),
        .writeData(wdata), .writeEnable(we), .readData(rdata)
    );

    sram_bank_we #(.WIDTH(TAGW), .LOG_NUM_ROWS(LR), .WORD_SIZE(TAGW)) u_tag (
        .clk(clk), .reset(reset), .readAddr(t_raddr), .writeAddr(t_waddr),
        .writeData(t_wdata), .writeEnable(t_we), .readData(t_rdata)
    );

    // One clock edge; the model applies writes before reading, giving write-first results.
    task automatic step();
        logic [DW-1:0] e;
        @(posedge clk);
        if (reset) begin
`ifdef SRAM_RESET_CLEAR_EN
            for (int r = 0; r < NR; r++) begin
                t[r] = '0;
                for (int w = 0; w < NW; w++) m[r][w] = '0;
            end
`endif
            exp_q.push_back('0);
            tag_q.push_back('0);
        end else begin
            for (int w = 0; w < NW; w++) if (we[w]) m[waddr][w] = wdata[w*WS +: WS];
            if (t_we[0]) t[t_waddr] = t_wdata;
            for (int w = 0; w < NW; w++) e[w*WS +: WS] = m[raddr][w];
            exp_q.push_back(e);
            tag_q.push_back(t[t_raddr]);
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; we = '0; t_we = '0;
        wdata = '0; t_wdata = '0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        logic [TAGW-1:0] et;
        idle_inputs();
        reset = 1'b1; we = '1; waddr = 4'd1; wdata = '1; raddr = 4'd1;
        step();
        e = exp_q.pop_front(); et = tag_q.pop_front();
        tests_run++;
        if (rdata !== e) begin
            tests_failed++;
            $display("FAIL reset_rdata got=%h exp=%h", rdata, e);
        end
        tests_run++;
        if (t_rdata !== et) begin
            tests_failed++;
            $display("FAIL reset_tag_rdata got=%h exp=%h", t_rdata, et);
        end
        idle_inputs();
        for (int r = 0; r < NR; r++) begin
            raddr = r[LR-1:0]; t_raddr = r[LR-1:0];
            step();
            e = exp_q.pop_front(); et = tag_q.pop_front();
            tests_run++;
            if (rdata !== e) begin
                tests_failed++;
                $display("FAIL reset_row%0d got=%h exp=%h", r, rdata, e);
            end
        end
    endtask

    task automatic test_full_row();
        logic [DW-1:0] line, e;
        idle_inputs();
        for (int i = 0; i < NW; i++) line[i*WS +: WS] = 32'hA5A5_0000 + i;
        waddr = 4'd3; we = 16'hFFFF; wdata = line; raddr = 4'd0;
        step();
        void'(exp_q.pop_front());
        idle_inputs(); raddr = 4'd3;
        step();
        e = exp_q.pop_front();
        tests_run++;
        if (rdata !== e || rdata !== line) begin
            tests_failed++;
            $display("FAIL full_row got=%h exp=%h", rdata, line);
        end
    endtask

    task automatic test_partial();
        logic [DW-1:0] e;
        idle_inputs();
        for (int i = 0; i < NW; i++) wdata[i*WS +: WS] = $urandom;
        wdata[3*WS +: WS] = 32'hDEAD_BEEF;
        wdata[2*WS +: WS] = 32'hCAFE_F00D;
        waddr = 4'd3; we = 16'h000C; raddr = 4'd0;
        step();
        void'(exp_q.pop_front());
        idle_inputs(); raddr = 4'd3;
        step();
        e = exp_q.pop_front();
        tests_run++;
        if (rdata !== e) begin
            tests_failed++;
            $display("FAIL partial_write got=%h exp=%h", rdata, e);
        end
        tests_run++;
        if (rdata[4*WS +: WS] !== 32'hA5A5_0004 || rdata[2*WS +: WS] !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL partial_words got=%h/%h exp=a5a50004/cafef00d",
                     rdata[4*WS +: WS], rdata[2*WS +: WS]);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] e;
        idle_inputs();
        for (int i = 0; i < NW; i++) wdata[i*WS +: WS] = $urandom;
        waddr = 4'd7; we = '1; raddr = 4'd0;
        step();
        void'(exp_q.pop_front());
        for (int i = 0; i < NW; i++) wdata[i*WS +: WS] = $urandom;
        wdata[15*WS +: WS] = 32'h2222_2222;
        wdata[14*WS +: WS] = 32'h1111_1111;
        waddr = 4'd7; raddr = 4'd7; we = 16'hC000;
        step();
        e = exp_q.pop_front();
        tests_run++;
        if (rdata !== e) begin
            tests_failed++;
            $display("FAIL write_first got=%h exp=%h", rdata, e);
        end
    endtask

    task automatic test_independent();
        logic [DW-1:0] e;
        idle_inputs();
        for (int i = 0; i < NW; i++) wdata[i*WS +: WS] = $urandom;
        waddr = 4'd9; we = '1; raddr = 4'd0;
        step();
        void'(exp_q.pop_front());
        for (int i = 0; i < NW; i++) wdata[i*WS +: WS] = $urandom;
        waddr = 4'd5; we = 16'h5A5A; raddr = 4'd9;
        step();
        e = exp_q.pop_front();
        tests_run++;
        if (rdata !== e) begin
            tests_failed++;
            $display("FAIL indep_read got=%h exp=%h", rdata, e);
        end
        idle_inputs(); raddr = 4'd5;
        step();
        e = exp_q.pop_front();
        tests_run++;
        if (rdata !== e) begin
            tests_failed++;
            $display("FAIL indep_write got=%h exp=%h", rdata, e);
        end
    endtask

    task automatic test_tag();
        logic [TAGW-1:0] et;
        idle_inputs();
        tag_q.delete(); exp_q.delete();
        t_we = 1'b1; t_waddr = 4'd2; t_wdata = 54'h3F_FFFF_FFFF_FFFF; t_raddr = 4'd0;
        step();
        t_we = 1'b0; t_raddr = 4'd2;
        step();
        void'(tag_q.pop_front());
        et = tag_q.pop_front();
        tests_run++;
        if (t_rdata !== et || t_rdata !== 54'h3F_FFFF_FFFF_FFFF) begin
            tests_failed++;
            $display("FAIL tag_read got=%h exp=%h", t_rdata, et);
        end
        reset = 1'b1; t_we = 1'b1; t_wdata = 54'h12_3456_789A_BCDE;
        step();
        et = tag_q.pop_front();
        tests_run++;
        if (t_rdata !== et) begin
            tests_failed++;
            $display("FAIL tag_reset_rdata got=%h exp=%h", t_rdata, et);
        end
        reset = 1'b0; t_we = 1'b0;
        step();
        et = tag_q.pop_front();
        tests_run++;
        if (t_rdata !== et) begin
            tests_failed++;
            $display("FAIL tag_write_dropped got=%h exp=%h", t_rdata, et);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_contents();
        logic [DW-1:0] e;
        idle_inputs();
        exp_q.delete();
        reset = 1'b1;
        step();
        void'(exp_q.pop_front());
        reset = 1'b0;
        for (int r = 0; r < NR; r++) begin
            raddr = r[LR-1:0];
            step();
            e = exp_q.pop_front();
            tests_run++;
            if (rdata !== e) begin
                tests_failed++;
                $display("FAIL post_reset_row%0d got=%h exp=%h", r, rdata, e);
            end
        end
        tag_q.delete();
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        logic [TAGW-1:0] et;
        idle_inputs();
        exp_q.delete(); tag_q.delete();
        for (int n = 0; n < 300; n++) begin
            raddr = LR'($urandom_range(0, NR-1));
            waddr = ($urandom_range(0, 3) == 0) ? raddr : LR'($urandom_range(0, NR-1));
            for (int i = 0; i < NW; i++) wdata[i*WS +: WS] = $urandom;
            we = NW'({$urandom, $urandom} >> $urandom_range(0, 16));
            t_raddr = LR'($urandom_range(0, NR-1));
            t_waddr = ($urandom_range(0, 1) == 0) ? t_raddr : LR'($urandom_range(0, NR-1));
            t_wdata = TAGW'({$urandom, $urandom});
            t_we = 1'($urandom_range(0, 1));
            step();
            e = exp_q.pop_front(); et = tag_q.pop_front();
            tests_run++;
            if (rdata !== e) begin
                tests_failed++;
                $display("FAIL random_data n=%0d got=%h exp=%h", n, rdata, e);
            end
            tests_run++;
            if (t_rdata !== et) begin
                tests_failed++;
                $display("FAIL random_tag n=%0d got=%h exp=%h", n, t_rdata, et);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            t[r] = '0;
            for (int w = 0; w < NW; w++) m[r][w] = '0;
        end
        reset = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0;
        t_raddr = '0; t_waddr = '0; t_wdata = '0; t_we = '0;
        #2;
        test_reset();
        test_full_row();
        test_partial();
        test_bypass();
        test_independent();
        test_tag();
        test_random();
        test_reset_contents();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
